// File: rtl/ts_win_ctrl.sv
// ts_win_ctrl: frame timeslot window scheduler for the bit-to-byte packer.
module ts_win_ctrl (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic        cfg_ts0_en,
   input  logic        cfg_ts1_en,
   input  logic [15:0] cfg_ts0_len,
   input  logic [15:0] cfg_ts1_len,
   input  logic        ldpc_en_out,
   output logic        ts0_win,
   output logic        ts1_win,
   output logic [15:0] byte_cnt,
   output logic        busy,
   output logic        frame_done,
   output logic        ovf_err
);
   typedef enum logic [1:0] {IDLE, TS0, TS1, DONE} state_t;
   state_t state;
   logic [18:0] bit_cnt;
   logic sh0_en, sh1_en;
   logic [15:0] sh0_len, sh1_len, cur_len;
   logic cfg0_act, cfg1_act, ts0_act, ts1_act, last_bit;
   assign cfg0_act = cfg_ts0_en && |cfg_ts0_len;
   assign cfg1_act = cfg_ts1_en && |cfg_ts1_len;
   assign ts0_act = sh0_en && |sh0_len;
   assign ts1_act = sh1_en && |sh1_len;
   assign cur_len = state == TS1 ? sh1_len : sh0_len;
   // last bit of a slot sits at len*8-1, so windows always close on a byte boundary
   assign last_bit = ldpc_en_out && bit_cnt == {cur_len - 16'd1, 3'b111};
   assign ts0_win = state == TS0;
   assign ts1_win = state == TS1;
   assign busy = state != IDLE;
   assign frame_done = state == DONE;
   assign byte_cnt = bit_cnt[18:3];
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         bit_cnt <= '0;
         sh0_en <= 1'b0;
         sh1_en <= 1'b0;
         sh0_len <= '0;
         sh1_len <= '0;
         ovf_err <= 1'b0;
      end else begin
         ovf_err <= ldpc_en_out && (state == IDLE || state == DONE);
         case (state)
            IDLE: begin
               bit_cnt <= '0;
               if (frame_start) begin
                  sh0_en <= cfg_ts0_en;
                  sh1_en <= cfg_ts1_en;
                  sh0_len <= cfg_ts0_len;
                  sh1_len <= cfg_ts1_len;
                  state <= cfg0_act ? TS0 : cfg1_act ? TS1 : DONE;
               end
            end
            TS0: begin
               if (last_bit || !ts0_act) begin
                  bit_cnt <= '0;
                  state <= ts1_act ? TS1 : DONE;
               end else if (ldpc_en_out) bit_cnt <= bit_cnt + 19'd1;
            end
            TS1: begin
               if (last_bit || !ts1_act) begin
                  bit_cnt <= '0;
                  state <= DONE;
               end else if (ldpc_en_out) bit_cnt <= bit_cnt + 19'd1;
            end
            default: begin
               bit_cnt <= '0;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_ts_win_ctrl.sv
// tb_ts_win_ctrl: scoreboard bench for ts_win_ctrl with directed frame schedules.
module tb_ts_win_ctrl;
   logic clk = 0, reset_n = 0, frame_start = 0, cfg_ts0_en = 0, cfg_ts1_en = 0, ldpc_en_out = 0;
   logic [15:0] cfg_ts0_len = 0, cfg_ts1_len = 0;
   logic ts0_win, ts1_win, busy, frame_done, ovf_err;
   logic [15:0] byte_cnt;
   int checks = 0, passed = 0;
   typedef struct {bit ovf; int b0; int b1; int c0; int c1; int prev; int lat;} exp_t;
   exp_t q[$];
   int b0 = 0, b1 = 0, c0 = 0, c1 = 0, since = 0, prev_w = 0;
   bit armed = 1, busy_chk = 0;
   always #5 clk = ~clk;
   ts_win_ctrl dut (
      .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
      .cfg_ts0_en(cfg_ts0_en), .cfg_ts1_en(cfg_ts1_en),
      .cfg_ts0_len(cfg_ts0_len), .cfg_ts1_len(cfg_ts1_len),
      .ldpc_en_out(ldpc_en_out), .ts0_win(ts0_win), .ts1_win(ts1_win),
      .byte_cnt(byte_cnt), .busy(busy), .frame_done(frame_done), .ovf_err(ovf_err)
   );
   task automatic chk(input string name, input int act, input int exp_v);
      checks++;
      if (act == exp_v) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic frame(input bit e0, input bit e1, input int l0, input int l1);
      cfg_ts0_en = e0;
      cfg_ts1_en = e1;
      cfg_ts0_len = 16'(l0);
      cfg_ts1_len = 16'(l1);
      frame_start = 1;
      step();
      frame_start = 0;
   endtask
   task automatic push_frame(input int eb0, input int eb1, input int ec0, input int ec1, input int ep, input int el);
      q.push_back('{1'b0, eb0, eb1, ec0, ec1, ep, el});
   endtask
   // monitor: accumulates window activity and scores each frame_done / ovf_err against the queue
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n) begin
         b0 = 0; b1 = 0; c0 = 0; c1 = 0; prev_w = 0; armed = 1; busy_chk = 0;
      end else begin
         chk("win_overlap", int'(ts0_win & ts1_win), 0);
         if (busy_chk) begin
            chk("busy_after_done", int'(busy), 0);
            busy_chk = 0;
         end
         if (frame_start && armed) begin
            since = 0;
            armed = 0;
         end else since++;
         if (ovf_err) begin
            chk("ovf_expected", int'(q.size() > 0 && q[0].ovf), 1);
            if (q.size() > 0 && q[0].ovf) void'(q.pop_front());
         end
         if (frame_done) begin
            chk("done_expected", int'(q.size() > 0 && !q[0].ovf), 1);
            if (q.size() > 0 && !q[0].ovf) begin
               e = q.pop_front();
               chk("ts0_bits", b0, e.b0);
               chk("ts1_bits", b1, e.b1);
               chk("ts0_cycles", c0, e.c0);
               chk("ts1_cycles", c1, e.c1);
               chk("last_window", prev_w, e.prev);
               chk("done_latency", since, e.lat);
            end
            b0 = 0; b1 = 0; c0 = 0; c1 = 0; armed = 1; busy_chk = 1;
         end
         if (ts0_win) begin c0++; if (ldpc_en_out) b0++; end
         if (ts1_win) begin c1++; if (ldpc_en_out) b1++; end
         prev_w = ts0_win ? 1 : ts1_win ? 2 : 0;
      end
   end
   initial begin
      repeat (3) step();
      chk("rst_ts0_win", ts0_win, 0);
      chk("rst_ts1_win", ts1_win, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_ovf_err", ovf_err, 0);
      chk("rst_byte_cnt", byte_cnt, 0);
      reset_n = 1;
      repeat (2) step();
      // two-slot frame, continuous bits
      push_frame(16, 24, 16, 24, 2, 41);
      frame(1, 1, 2, 3);
      ldpc_en_out = 1;
      repeat (12) step();
      chk("byte_cnt_ts0", byte_cnt, 1);
      repeat (21) step();
      chk("byte_cnt_ts1", byte_cnt, 2);
      repeat (7) step();
      ldpc_en_out = 0;
      repeat (4) step();
      // gapped stream, ts1 disabled
      push_frame(8, 0, 16, 0, 1, 17);
      frame(1, 0, 1, 5);
      for (int i = 0; i < 16; i++) begin
         ldpc_en_out = i[0];
         step();
      end
      ldpc_en_out = 0;
      repeat (4) step();
      // empty schedule
      push_frame(0, 0, 0, 0, 0, 1);
      frame(1, 1, 0, 0);
      repeat (4) step();
      // config isolation: restart attempt and cfg change mid-TS0
      push_frame(16, 8, 16, 8, 2, 25);
      frame(1, 1, 2, 1);
      ldpc_en_out = 1;
      for (int i = 0; i < 24; i++) begin
         frame_start = i == 5;
         if (i == 5) begin
            cfg_ts0_len = 16'd5;
            cfg_ts1_len = 16'd4;
         end
         step();
      end
      frame_start = 0;
      ldpc_en_out = 0;
      repeat (4) step();
      // reset after 5 bits in TS1, with frame_start and bits in the reset cycle
      frame(1, 1, 1, 2);
      ldpc_en_out = 1;
      repeat (13) step();
      chk("ts1_before_rst", ts1_win, 1);
      reset_n = 0;
      frame_start = 1;
      step();
      chk("abort_ts0_win", ts0_win, 0);
      chk("abort_ts1_win", ts1_win, 0);
      chk("abort_busy", busy, 0);
      chk("abort_frame_done", frame_done, 0);
      chk("abort_ovf_err", ovf_err, 0);
      chk("abort_byte_cnt", byte_cnt, 0);
      reset_n = 1;
      frame_start = 0;
      ldpc_en_out = 0;
      repeat (2) step();
      chk("idle_after_abort", busy, 0);
      // overflow in IDLE
      q.push_back('{1'b1, 0, 0, 0, 0, 0, 0});
      ldpc_en_out = 1;
      step();
      ldpc_en_out = 0;
      chk("ovf_byte_cnt", byte_cnt, 0);
      repeat (4) step();
      chk("ovf_busy", busy, 0);
      chk("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
